full_adder_reg: RTL and testbench
=================================

# full_adder_reg

Parameterizable ripple-carry full adder with an optional output register stage. With WIDTH = 1 it is the classic one-bit full adder (A + B + carry-in → sum, carry-out) used as the base cell of the adder library. Wider instances chain WIDTH one-bit cells LSB to MSB. It sits in datapaths that need either a purely combinational add or a single-cycle registered add.

## Interface
- WIDTH, default 1: operand and sum width in bits, ≥ 1.
- REG_OUT, default 0: 0 makes outputs combinational, 1 registers the outputs (one-cycle latency).

- Clk_i  input  1  clock, rising-edge; used only when REG_OUT = 1.
- Rst_i  input  1  reset, synchronous, active-high; used only when REG_OUT = 1.
- A_i  input  WIDTH  operand A, unsigned.
- B_i  input  WIDTH  operand B, unsigned.
- C_i  input  1  carry-in.
- Valid_i  input  1  input qualifier; when REG_OUT = 1 it gates capture of the result.
- S_o  output  WIDTH  sum, A_i + B_i + C_i modulo 2^WIDTH.
- C_o  output  1  carry-out, bit WIDTH of the full sum.
- Valid_o  output  1  result-valid qualifier.

## Operation
- Bit cell i: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])); c[0] = C_i.
- Ripple chain: {C_o, S_o} = A_i + B_i + C_i, computed to WIDTH+1 bits, so it never overflows.
- The sum is built from explicit per-bit cells in a generate loop, not a single "+" operator, so that the carry chain is visible.

**REG_OUT = 0**
- S_o, C_o and Valid_o follow A_i, B_i, C_i and Valid_i combinationally.
- Clk_i and Rst_i have no effect.
- There is no reset value; outputs are defined whenever the inputs are.

**REG_OUT = 1**
- On each rising edge of Clk_i with Rst_i = 1: S_o ← 0, C_o ← 0, Valid_o ← 0.
- Otherwise, if Valid_i = 1: S_o and C_o capture the combinational result, and Valid_o ← 1.
- Otherwise, with Valid_i = 0: S_o and C_o hold their previous values, and Valid_o ← 0.
- Reset has priority over Valid_i on the same edge.
- Reset asserted mid-stream discards any pending result; the first valid input after reset deasserts appears one cycle later.

## Timing
- REG_OUT = 0: zero latency; the only delay is the propagation delay of the WIDTH-cell carry chain.
- REG_OUT = 1: one-cycle latency from Valid_i sampled high at edge N to Valid_o = 1 with the result after edge N.
- Throughput is one result per cycle, with no stall or backpressure.
- Back-to-back Valid_i pulses produce back-to-back Valid_o pulses with matching results.
- Reset values (REG_OUT = 1): S_o = 0, C_o = 0, Valid_o = 0.

## Test plan
- **Exhaustive 1-bit truth table (WIDTH = 1, REG_OUT = 0).** Apply all 8 combinations of {A_i, B_i, C_i}, 10 time units apart. Required {C_o, S_o}:
  - 000 → 00, 100 → 01, 010 → 01, 110 → 10
  - 001 → 01, 101 → 10, 011 → 10, 111 → 11
- **Wide carry ripple (WIDTH = 8, REG_OUT = 0).** A_i = 8'hFF, B_i = 8'h00, C_i = 1 → S_o = 8'h00, C_o = 1. Then A_i = 8'h7F, B_i = 8'h01, C_i = 0 → S_o = 8'h80, C_o = 0.
- **Registered latency (WIDTH = 8, REG_OUT = 1).** Release reset, then apply Valid_i = 1 with A_i = 8'h12, B_i = 8'h34, C_i = 1 at edge N → after edge N: S_o = 8'h47, C_o = 0, Valid_o = 1. With Valid_i = 0 at edge N+1 → S_o holds 8'h47 and Valid_o = 0.
- **Reset behaviour (REG_OUT = 1).** Assert Rst_i = 1 together with Valid_i = 1, A_i = 8'hFF, B_i = 8'hFF, C_i = 1 → after the edge: S_o = 0, C_o = 0, Valid_o = 0. Deassert Rst_i → the next edge gives S_o = 8'hFF, C_o = 1, Valid_o = 1.
- **Streaming (WIDTH = 4, REG_OUT = 1).** Keep Valid_i = 1 for 16 consecutive cycles with A_i = k, B_i = 15 − k, C_i = k[0], for k = 0 to 15 → each cycle one edge later: S_o = (15 + k[0]) mod 16, C_o = k[0], Valid_o = 1 on every cycle, with no bubbles.
- **Random compare (WIDTH = 16, both REG_OUT values).** Apply 1000 random vectors and check {C_o, S_o} = A_i + B_i + C_i against a reference model, with one-cycle alignment when REG_OUT = 1.

Source files
------------

// File: rtl/full_adder_reg.sv
// Ripple-carry adder built from explicit one-bit full-adder cells, with an
// optional single-cycle output register gated by Valid_i.
module full_adder_reg #(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  input  logic             C_i,
  input  logic             Valid_i,
  output logic [WIDTH-1:0] S_o,
  output logic             C_o,
  output logic             Valid_o
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = C_i;

  // One cell per bit so the carry chain stays explicit in the netlist.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic prop;
    assign prop         = A_i[i] ^ B_i[i];
    assign sum[i]       = prop ^ carry[i];
    assign carry[i+1]   = (A_i[i] & B_i[i]) | (carry[i] & prop);
  end

  if (REG_OUT) begin : g_reg
    always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
        S_o     <= '0;
        C_o     <= 1'b0;
        Valid_o <= 1'b0;
      end else if (Valid_i) begin
        S_o     <= sum;
        C_o     <= carry[WIDTH];
        Valid_o <= 1'b1;
      end else begin
        Valid_o <= 1'b0;
      end
    end
  end else begin : g_comb
    // Clock and reset are intentionally dead in the combinational variant.
    logic unused_ok;
    assign unused_ok = &{1'b0, Clk_i, Rst_i};

    assign S_o     = sum;
    assign C_o     = carry[WIDTH];
    assign Valid_o = Valid_i;
  end

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed and random checks of full_adder_reg in its combinational and
// registered configurations at several widths.
module tb_full_adder_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // WIDTH=1, combinational
  logic       a1, b1, c1, v1;
  logic       s1, co1, vo1;
  full_adder_reg #(.WIDTH(1), .REG_OUT(1'b0)) u_w1 (
    .Clk_i(clk), .Rst_i(rst), .A_i(a1), .B_i(b1), .C_i(c1), .Valid_i(v1),
    .S_o(s1), .C_o(co1), .Valid_o(vo1));

  // WIDTH=8, combinational
  logic [7:0] a8c, b8c, s8c;
  logic       c8c, v8c, co8c, vo8c;
  full_adder_reg #(.WIDTH(8), .REG_OUT(1'b0)) u_w8c (
    .Clk_i(clk), .Rst_i(rst), .A_i(a8c), .B_i(b8c), .C_i(c8c), .Valid_i(v8c),
    .S_o(s8c), .C_o(co8c), .Valid_o(vo8c));

  // WIDTH=8, registered
  logic [7:0] a8r, b8r, s8r;
  logic       c8r, v8r, co8r, vo8r;
  full_adder_reg #(.WIDTH(8), .REG_OUT(1'b1)) u_w8r (
    .Clk_i(clk), .Rst_i(rst), .A_i(a8r), .B_i(b8r), .C_i(c8r), .Valid_i(v8r),
    .S_o(s8r), .C_o(co8r), .Valid_o(vo8r));

  // WIDTH=4, registered
  logic [3:0] a4, b4, s4;
  logic       c4, v4, co4, vo4;
  full_adder_reg #(.WIDTH(4), .REG_OUT(1'b1)) u_w4r (
    .Clk_i(clk), .Rst_i(rst), .A_i(a4), .B_i(b4), .C_i(c4), .Valid_i(v4),
    .S_o(s4), .C_o(co4), .Valid_o(vo4));

  // WIDTH=16, both variants share stimulus
  logic [15:0] a16, b16, s16c, s16r;
  logic        c16, v16, co16c, vo16c, co16r, vo16r;
  full_adder_reg #(.WIDTH(16), .REG_OUT(1'b0)) u_w16c (
    .Clk_i(clk), .Rst_i(rst), .A_i(a16), .B_i(b16), .C_i(c16), .Valid_i(v16),
    .S_o(s16c), .C_o(co16c), .Valid_o(vo16c));
  full_adder_reg #(.WIDTH(16), .REG_OUT(1'b1)) u_w16r (
    .Clk_i(clk), .Rst_i(rst), .A_i(a16), .B_i(b16), .C_i(c16), .Valid_i(v16),
    .S_o(s16r), .C_o(co16r), .Valid_o(vo16r));

  // {a,b,c} -> {co,s}, hand-computed
  logic [2:0] tt_in  [8] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
  logic [1:0] tt_out [8] = '{2'b00,  2'b01,  2'b01,  2'b10,  2'b01,  2'b10,  2'b10,  2'b11};

  logic [16:0] exp16;
  logic [15:0] hold16;
  logic        expv16;
  logic [2:0]  vec;

  initial begin
    {a1, b1, c1, v1} = '0;
    {a8c, b8c, c8c, v8c} = '0;
    {a8r, b8r, c8r, v8r} = '0;
    {a4, b4, c4, v4} = '0;
    {a16, b16, c16, v16} = '0;

    // Reset values of registered instances
    rst = 1'b1;
    tick();
    tick();
    check("rst_w8_s", 32'(s8r), 32'h0);
    check("rst_w8_c", 32'(co8r), 32'h0);
    check("rst_w8_v", 32'(vo8r), 32'h0);
    check("rst_w4_v", 32'(vo4), 32'h0);
    check("rst_w16_cs", 32'({co16r, s16r}), 32'h0);

    // 1-bit truth table
    for (int i = 0; i < 8; i++) begin
      vec = tt_in[i];
      {a1, b1, c1} = vec;
      v1 = vec[0];
      #10;
      check($sformatf("tt_%03b", vec), 32'({co1, s1}), 32'(tt_out[i]));
      check($sformatf("tt_v_%03b", vec), 32'(vo1), 32'(vec[0]));
    end

    // Wide carry ripple
    a8c = 8'hFF; b8c = 8'h00; c8c = 1'b1; v8c = 1'b1;
    #10;
    check("ripple_ff_s", 32'(s8c), 32'h00);
    check("ripple_ff_c", 32'(co8c), 32'h1);
    check("ripple_ff_v", 32'(vo8c), 32'h1);
    a8c = 8'h7F; b8c = 8'h01; c8c = 1'b0; v8c = 1'b0;
    #10;
    check("ripple_7f_s", 32'(s8c), 32'h80);
    check("ripple_7f_c", 32'(co8c), 32'h0);
    check("ripple_7f_v", 32'(vo8c), 32'h0);

    // Registered latency
    rst = 1'b0;
    a8r = 8'h12; b8r = 8'h34; c8r = 1'b1; v8r = 1'b1;
    tick();
    check("lat_s", 32'(s8r), 32'h47);
    check("lat_c", 32'(co8r), 32'h0);
    check("lat_v", 32'(vo8r), 32'h1);
    a8r = 8'hAA; b8r = 8'h11; v8r = 1'b0;
    tick();
    check("hold_s", 32'(s8r), 32'h47);
    check("hold_c", 32'(co8r), 32'h0);
    check("hold_v", 32'(vo8r), 32'h0);

    // Reset priority over Valid_i
    rst = 1'b1;
    a8r = 8'hFF; b8r = 8'hFF; c8r = 1'b1; v8r = 1'b1;
    tick();
    check("rstpri_s", 32'(s8r), 32'h0);
    check("rstpri_c", 32'(co8r), 32'h0);
    check("rstpri_v", 32'(vo8r), 32'h0);
    rst = 1'b0;
    tick();
    check("postrst_s", 32'(s8r), 32'hFF);
    check("postrst_c", 32'(co8r), 32'h1);
    check("postrst_v", 32'(vo8r), 32'h1);
    v8r = 1'b0;

    // Streaming, no bubbles
    for (int k = 0; k < 16; k++) begin
      a4 = 4'(k);
      b4 = 4'(15 - k);
      c4 = k[0];
      v4 = 1'b1;
      tick();
      check($sformatf("stream_s_%0d", k), 32'(s4), (k % 2 == 1) ? 32'h0 : 32'hF);
      check($sformatf("stream_c_%0d", k), 32'(co4), 32'(k[0]));
      check($sformatf("stream_v_%0d", k), 32'(vo4), 32'h1);
    end
    v4 = 1'b0;
    tick();
    check("stream_end_v", 32'(vo4), 32'h0);

    // Random compare, both variants; registered one also exercises hold
    hold16 = s16r;
    for (int n = 0; n < 1000; n++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      v16 = ($urandom_range(0, 3) != 0);
      if (n < 4) begin
        a16 = (n < 2) ? 16'hFFFF : 16'h0000;
        b16 = (n == 1) ? 16'h0000 : a16;
        c16 = 1'b1;
      end
      exp16 = {1'b0, a16} + {1'b0, b16} + {16'h0, c16};
      #1;
      check("rnd_comb", 32'({co16c, s16c}), 32'(exp16));
      check("rnd_comb_v", 32'(vo16c), 32'(v16));
      if (v16) begin
        hold16 = exp16[15:0];
        expv16 = 1'b1;
      end else begin
        expv16 = 1'b0;
      end
      tick();
      check("rnd_reg_s", 32'(s16r), 32'(hold16));
      check("rnd_reg_v", 32'(vo16r), 32'(expv16));
      if (v16) check("rnd_reg_c", 32'(co16r), 32'(exp16[16]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
